// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Signed extremes for a given width, returned in the low bits of a 64-bit word.
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into its top bit.
module rca_slice
    import rca_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor, STAGES slices of WIDTH/STAGES bits each.
// Define RCA_SAT_EN to saturate the sum to the signed extreme on overflow.
module rca_pipe_addsub
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("rca_pipe_addsub: WIDTH must be >= 2 and divisible by STAGES");
    end

`ifdef RCA_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
`endif

    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign b_in     = (op_sub == OP_SUB) ? ~b : b;
    assign c_in     = (op_sub == OP_ADD) ? cin : 1'b1;

    // Each stage forwards only the operand bits still to be added and the result bits already done.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [CHUNK-1:0] ca, cb, sl_s;
        logic             ci, vi, sl_co, sl_cm;
        logic             v_q, c_q;

        if (k == 0) begin : g_src
            assign ca = a[CHUNK-1:0];
            assign cb = b_in[CHUNK-1:0];
            assign ci = c_in;
            assign vi = in_valid;
        end else begin : g_src
            assign ca = stg[k-1].g_fwd.a_q[CHUNK-1:0];
            assign cb = stg[k-1].g_fwd.b_q[CHUNK-1:0];
            assign ci = stg[k-1].c_q;
            assign vi = stg[k-1].v_q;
        end

        rca_slice #(.W(CHUNK)) u_slice (
            .a        (ca),
            .b        (cb),
            .ci       (ci),
            .s        (sl_s),
            .co       (sl_co),
            .c_msb_in (sl_cm)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= vi;
                c_q <= sl_co;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int unsigned HI_W = WIDTH - (k + 1) * CHUNK;
            localparam int unsigned LO_W = (k + 1) * CHUNK;
            logic [HI_W-1:0] a_q, b_q, a_n, b_n;
            logic [LO_W-1:0] s_q, s_n;

            if (k == 0) begin : g_nxt
                assign a_n = a[WIDTH-1:CHUNK];
                assign b_n = b_in[WIDTH-1:CHUNK];
                assign s_n = sl_s;
            end else begin : g_nxt
                assign a_n = stg[k-1].g_fwd.a_q[WIDTH-k*CHUNK-1:CHUNK];
                assign b_n = stg[k-1].g_fwd.b_q[WIDTH-k*CHUNK-1:CHUNK];
                assign s_n = {sl_s, stg[k-1].g_fwd.s_q};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv) begin
                    a_q <= a_n;
                    b_q <= b_n;
                    s_q <= s_n;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] raw, res, sum_q;
            logic             ovf, ovf_q;

            if (k == 0) begin : g_raw
                assign raw = sl_s;
            end else begin : g_raw
                assign raw = {sl_s, stg[k-1].g_fwd.s_q};
            end

            assign ovf = sl_cm ^ sl_co;

            always_comb begin
                res = raw;
`ifdef RCA_SAT_EN
                if (ovf) res = ca[CHUNK-1] ? SMIN : SMAX;
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q <= '0;
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    sum_q <= res;
                    ovf_q <= ovf;
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign cout      = stg[STAGES-1].c_q;
    assign sum       = stg[STAGES-1].g_out.sum_q;
    assign overflow  = stg[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench: directed vectors, bubbles, back-pressure, reset and a 1-stage 6-bit instance.
module tb_rca_pipe_addsub;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, sum;
    logic          cin, op_sub, cout, overflow;

    logic          iv6, ir6, ov6, or6, cin6, sub6, co6, ovf6;
    logic [5:0]    a6, b6, sum6;

    int            n_total = 0;
    int            n_bad   = 0;
    int            n_out   = 0;
    bit            rnd     = 1'b0;
    res_t          sb[$];

    always #5 clk = ~clk;

    rca_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    rca_pipe_addsub #(.WIDTH(6), .STAGES(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6),
        .a(a6), .b(b6), .cin(cin6), .op_sub(sub6), .out_valid(ov6),
        .out_ready(or6), .sum(sum6), .cout(co6), .overflow(ovf6)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: true signed/unsigned arithmetic, then wrap or saturate.
    function automatic res_t model(input int unsigned w, input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic sub);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ux   = longint'(x) & m;
        longint uy   = longint'(y) & m;
        longint sx   = (ux >= half) ? ux - (m + 1) : ux;
        longint sy   = (uy >= half) ? uy - (m + 1) : uy;
        longint t, r;
        res_t   o;
        if (sub) begin
            t    = sx - sy;
            o.co = (ux >= uy);
        end else begin
            t    = sx + sy + longint'(c);
            o.co = (ux + uy + longint'(c)) > m;
        end
        o.ov = (t > half - 1) || (t < -half);
        r    = t & m;
`ifdef RCA_SAT_EN
        if (o.ov) r = (t > 0) ? half - 1 : half;
`endif
        o.s = 16'(r & m);
        return o;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    bit          was_stall = 1'b0;
    logic [15:0] p_sum;
    logic [1:0]  p_flags;

    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            sb.delete();
            was_stall = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (was_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_sum", sum, p_sum);
                chk("hold_flags", {cout, overflow}, p_flags);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_sum", sum, e.s);
                    chk("sb_cout", cout, e.co);
                    chk("sb_ovf", overflow, e.ov);
                end
                n_out++;
            end
            if (in_valid && in_ready) sb.push_back(model(W, a, b, cin, op_sub));
            was_stall = out_valid && !out_ready;
            p_sum     = sum;
            p_flags   = {cout, overflow};
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic sub);
        bit ok = 1'b0;
        a = x; b = y; cin = c; op_sub = sub; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        chk("send_accepted", ok, 1'b1);
    endtask

    task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic c, input logic sub,
                           input logic [15:0] es, input logic ec, input logic eo);
        int n = 0;
        send(x, y, c, sub);
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, S - 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, overflow, eo);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int target, input string tag);
        int n = 0;
        while ((n_out < target || out_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_count"}, n_out, target);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        logic [11:0] obs, expv;
        int          n0, cnt;
        res_t        e6;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        iv6 = 1'b0; or6 = 1'b1; a6 = '0; b6 = '0; cin6 = 1'b0; sub6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_valid6", ov6, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("add", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
`ifdef RCA_SAT_EN
        run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        run_one("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Bubbles: valid pattern 1,0,1,0 emerges unchanged after the pipeline latency.
        n0 = n_out;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 4) && (i % 2 == 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
            @(posedge clk);
            #1;
            obs[i]  = out_valid;
            expv[i] = (i >= int'(S) - 1) && (i - (int'(S) - 1) < 4) && ((i - (int'(S) - 1)) % 2 == 0);
        end
        in_valid = 1'b0;
        chk("bubble_pattern", obs, expv);
        wait_drain(n0 + 2, "bubble");

        // Back-pressure: 8 back-to-back ops against random out_ready.
        rnd = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 8; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_drain(n0 + 8, "bp");

        // Longer random stream with idle gaps, including operand corner values.
        n0 = n_out;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] x, y;
            x = (i % 7 == 0) ? 16'h7FFF : (i % 11 == 0) ? 16'h8000 : 16'($urandom);
            y = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
            send(x, y, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain(n0 + 40, "stream");
        rnd = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with three ops in flight: everything discarded.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h0444, 1'b1, 1'b0);
        send(16'h5555, 16'h0666, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_sum", sum, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        chk("midrst_no_results", cnt, 0);

        // Single-stage 6-bit instance: latency 1.
        a6 = 6'h1F; b6 = 6'h01; cin6 = 1'b0; sub6 = 1'b0; iv6 = 1'b1;
        @(negedge clk);
        chk("w6_in_ready", ir6, 1'b1);
        @(posedge clk);
        #1;
        iv6 = 1'b0;
        chk("w6_lat_valid", ov6, 1'b1);
`ifdef RCA_SAT_EN
        chk("w6_sum", sum6, 6'h1F);
`else
        chk("w6_sum", sum6, 6'h20);
`endif
        chk("w6_ovf", ovf6, 1'b1);
        chk("w6_cout", co6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a6 = 6'($urandom); b6 = 6'($urandom); cin6 = 1'($urandom); sub6 = 1'($urandom); iv6 = 1'b1;
            e6 = model(6, {10'd0, a6}, {10'd0, b6}, cin6, sub6);
            @(posedge clk);
            #1;
            iv6 = 1'b0;
            chk("w6_rnd_valid", ov6, 1'b1);
            chk("w6_rnd_sum", sum6, e6.s[5:0]);
            chk("w6_rnd_flags", {co6, ovf6}, {e6.co, e6.ov});
        end
        @(posedge clk);
        #1;
        chk("w6_idle_valid", ov6, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
